booth_divider: RTL and testbench
================================

BOOTH_DIVIDER -- requirements
Module: booth_divider

Interface
REQ-001 Parameter: WIDTH, default 4, divisor/quotient/remainder width; the dividend is 2*WIDTH bits.
REQ-002 Port: clk  input  1  single clock, rising-edge active.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: start  input  1  request a division; sampled only in IDLE.
REQ-005 Port: dividend  input  2*WIDTH  two's-complement dividend, captured on the accepting edge.
REQ-006 Port: divisor  input  WIDTH  two's-complement divisor, captured on the accepting edge.
REQ-007 Port: quotient  output  WIDTH  two's-complement quotient, registered.
REQ-008 Port: remainder  output  WIDTH  two's-complement remainder, registered.
REQ-009 Port: busy  output  1  high from the accepting edge until done is asserted.
REQ-010 Port: done  output  1  one-cycle pulse; results and flags valid.
REQ-011 Port: div_by_zero  output  1  sticky until the next accepted start; divisor was 0.
REQ-012 Port: overflow  output  1  sticky until the next accepted start; quotient not representable in WIDTH signed bits.

Function
REQ-013 States SHALL be IDLE, CALC, FIX and DONE.
REQ-014 Transition IDLE->CALC on an edge with start=1 and divisor!=0; on that edge, load |dividend| (2*WIDTH bits) and |divisor|, latch the operand signs, clear the flags and set busy=1.
REQ-015 Transition IDLE->DONE on an edge with start=1 and divisor=0; set div_by_zero=1, quotient=0 and remainder=0.
REQ-016 CALC SHALL perform restoring division on magnitudes, one quotient bit per edge, MSB first, for exactly 2*WIDTH edges, counted by an internal counter; the partial remainder is WIDTH+1 bits.
REQ-017 Transition CALC->FIX after the 2*WIDTH-th iteration edge.
REQ-018 The FIX edge SHALL apply signs as follows, then transition to DONE.
- Quotient sign = dividend sign XOR divisor sign.
- Remainder sign = dividend sign; a zero remainder stays 0.
- Results are truncated toward zero.
REQ-019 The FIX edge SHALL set overflow=1, quotient=0 and remainder=0 when the signed quotient lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-020 DONE SHALL hold done=1 for exactly one cycle, with busy=0 in that cycle, then return to IDLE on the next edge.
REQ-021 Latency: for a nonzero divisor, done SHALL be high in the cycle following edge 2*WIDTH+1 after the accepting edge (9 edges for WIDTH=4); for a zero divisor, after edge 1.
REQ-022 start SHALL be ignored in CALC, FIX and DONE; the operands are not re-captured.
REQ-023 start held high continuously SHALL start a new division on the first IDLE edge after DONE.
REQ-024 quotient, remainder and the flags SHALL hold their values from DONE until the next accepting edge.
REQ-025 The most negative dividend (-2^(2*WIDTH-1)) SHALL be handled through its 2*WIDTH-bit magnitude with no internal wrap.
REQ-026 The most negative divisor (-2^(WIDTH-1)) SHALL be handled through its WIDTH-bit magnitude with no internal wrap.

Reset
REQ-027 While rst=1, regardless of clk, the state SHALL be IDLE, and quotient, remainder, busy, done, div_by_zero, overflow and the iteration counter SHALL all be 0.
REQ-028 Reset asserted mid-CALC SHALL abort the operation with no done pulse; the first start accepted after rst deasserts SHALL compute normally.

Verification
REQ-029 dividend=8'd20, divisor=4'd3, start pulse -> done after 9 edges, quotient=4'b0110, remainder=4'b0010, no flags set.
REQ-030 dividend=-20 (8'hEC), divisor=3 -> quotient=4'b1010 (-6), remainder=4'b1110 (-2); dividend=20, divisor=-3 -> quotient=4'b1010, remainder=4'b0010.
REQ-031 Overflow boundary cases:
- dividend=-24 (8'hE8), divisor=3 -> quotient=4'b1000, overflow=0.
- dividend=100, divisor=3 -> overflow=1, quotient=0, remainder=0.
- dividend=-128, divisor=-8 -> overflow=1.
REQ-032 divisor=0, any dividend -> done one edge after acceptance, div_by_zero=1, quotient=0, remainder=0, busy never high for more than one cycle.
REQ-033 start re-pulsed with new operands during CALC -> ignored; the result matches the first operands, with exactly one done pulse.
REQ-034 rst pulsed at CALC iteration 3 -> all outputs 0 immediately, no done pulse; next start with 20/3 -> quotient=6, remainder=2.

Source files
------------

// File: rtl/booth_divider.sv
// Sequential signed divider: 2*WIDTH-bit dividend by WIDTH-bit divisor.
// Magnitudes are divided by restoring division, one quotient bit per clock,
// MSB first. Signs are applied in a single fix-up cycle that also checks
// whether the quotient fits in WIDTH signed bits.
module booth_divider #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           r_state, w_next;
  logic [DW-1:0]    r_dvd;    // dividend magnitude, quotient bits shift in at LSB
  logic [WIDTH-1:0] r_rem;    // remainder magnitude between iterations
  logic [WIDTH-1:0] r_dsr;    // divisor magnitude
  logic             r_sdvd, r_sdsr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot, r_remo;
  logic             r_busy, r_dz, r_ovf;

  logic [DW-1:0]    w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic [WIDTH:0]   w_trial, w_diff;
  logic             w_qbit, w_last, w_qneg, w_ovf;
  logic [DW-1:0]    w_lim;

  // Magnitudes are unsigned, so the most negative operands fit without wrap.
  assign w_dvd_mag = dividend[DW-1]   ? DW'(-dividend)   : dividend;
  assign w_dsr_mag = divisor[WIDTH-1] ? WIDTH'(-divisor) : divisor;

  // Partial remainder is WIDTH+1 bits: old remainder shifted with the next
  // dividend bit. A negative difference (borrow) means "restore".
  assign w_trial = {r_rem, r_dvd[DW-1]};
  assign w_diff  = w_trial - {1'b0, r_dsr};
  assign w_qbit  = ~w_diff[WIDTH];
  assign w_last  = (r_cnt == CW'(DW - 1));

  // Negative quotients may reach one further than positive ones.
  assign w_qneg = r_sdvd ^ r_sdsr;
  assign w_lim  = DW'((1 << (WIDTH - 1)) - 1) + DW'(w_qneg);
  assign w_ovf  = (r_dvd > w_lim);

  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign busy        = r_busy;
  assign done        = (r_state == DONE);
  assign div_by_zero = r_dz;
  assign overflow    = r_ovf;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = (divisor == '0) ? DONE : CALC;
      CALC: if (w_last) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate in CALC, sign/overflow fix-up in FIX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd  <= '0;
      r_rem  <= '0;
      r_dsr  <= '0;
      r_sdvd <= 1'b0;
      r_sdsr <= 1'b0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_remo <= '0;
      r_busy <= 1'b0;
      r_dz   <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd  <= w_dvd_mag;
            r_dsr  <= w_dsr_mag;
            r_sdvd <= dividend[DW-1];
            r_sdsr <= divisor[WIDTH-1];
            r_rem  <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            if (divisor == '0) begin
              r_dz   <= 1'b1;
              r_quot <= '0;
              r_remo <= '0;
              r_busy <= 1'b0;
            end else begin
              r_dz   <= 1'b0;
              r_busy <= 1'b1;
            end
          end
        end
        CALC: begin
          r_rem <= w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
          r_dvd <= {r_dvd[DW-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
        end
        FIX: begin
          r_busy <= 1'b0;
          if (w_ovf) begin
            r_ovf  <= 1'b1;
            r_quot <= '0;
            r_remo <= '0;
          end else begin
            r_quot <= w_qneg ? WIDTH'(-r_dvd[WIDTH-1:0]) : r_dvd[WIDTH-1:0];
            // Negating a zero remainder leaves it zero.
            r_remo <= r_sdvd ? WIDTH'(-r_rem) : r_rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider (WIDTH=4): scoreboard of expected
// results built from a signed integer model, popped when done pulses.
module tb_booth_divider;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic [W-1:0]   quotient, remainder;
  logic           busy, done, div_by_zero, overflow;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } res_t;

  res_t sb[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  function automatic res_t model(input logic [2*W-1:0] a, input logic [W-1:0] b);
    int sa, sbv, q, r;
    res_t e;
    sa  = $signed(a);
    sbv = $signed(b);
    e = '0;
    if (sbv == 0) e.dz = 1'b1;
    else begin
      q = sa / sbv;
      r = sa % sbv;
      if (q < -(1 << (W - 1)) || q > (1 << (W - 1)) - 1) e.ov = 1'b1;
      else begin
        e.q = q[W-1:0];
        e.r = r[W-1:0];
      end
    end
    return e;
  endfunction

  // Drive one start pulse; returns one step after the accepting edge.
  task automatic issue(input logic [2*W-1:0] a, input logic [W-1:0] b, input bit push);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #2;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0", {quotient, remainder, busy, done, div_by_zero, overflow});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors;
    logic [2*W-1:0] va[10] = '{8'd20, 8'hEC, 8'd20, 8'hE8, 8'd100, 8'h80, 8'h80, 8'd56, 8'hC0, 8'hC7};
    logic [W-1:0]   vb[10] = '{4'd3, 4'd3, 4'hD, 4'd3, 4'd3, 4'h8, 4'd7, 4'h8, 4'h8, 4'h8};
    int n;
    res_t got, exp;
    for (int i = 0; i < 10; i++) begin
      issue(va[i], vb[i], 1'b1);
      checks++;
      if (busy !== 1'b1) begin
        failures++; $display("FAIL vec%0d_busy got=%b want=1", i, busy);
      end
      wait_done(n);
      checks++;
      if (n !== 2 * W + 1) begin
        failures++; $display("FAIL vec%0d_latency got=%0d want=%0d", i, n, 2 * W + 1);
      end
      checks++;
      if (busy !== 1'b0) begin
        failures++; $display("FAIL vec%0d_busy_in_done got=%b want=0", i, busy);
      end
      got = {quotient, remainder, div_by_zero, overflow};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL vec%0d_result got=%h want=%h", i, got, exp);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || {quotient, remainder, div_by_zero, overflow} !== exp) begin
        failures++; $display("FAIL vec%0d_after_done done=%b got=%h want=%h", i, done,
                             {quotient, remainder, div_by_zero, overflow}, exp);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [2*W-1:0] va[2] = '{8'd77, 8'h80};
    int n;
    res_t got, exp;
    for (int i = 0; i < 2; i++) begin
      issue(va[i], 4'd0, 1'b1);
      checks++;
      if (busy !== 1'b0) begin
        failures++; $display("FAIL dz%0d_busy got=%b want=0", i, busy);
      end
      wait_done(n);
      checks++;
      if (n !== 0) begin
        failures++; $display("FAIL dz%0d_latency got=%0d want=0", i, n);
      end
      got = {quotient, remainder, div_by_zero, overflow};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL dz%0d_result got=%h want=%h", i, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_start;
    int pulses = 0;
    res_t got = '0, exp;
    issue(8'd20, 4'd3, 1'b1);
    for (int c = 0; c < 30; c++) begin
      if (c == 2) begin
        dividend = 8'd100; divisor = 4'd0; start = 1'b1;
      end
      if (c == 3) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        got = {quotient, remainder, div_by_zero, overflow};
      end
    end
    exp = sb.pop_front();
    checks++;
    if (pulses !== 1) begin
      failures++; $display("FAIL ignore_done_count got=%0d want=1", pulses);
    end
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL ignore_result got=%h want=%h", got, exp);
    end
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== exp) begin
      failures++; $display("FAIL ignore_hold got=%h want=%h", {quotient, remainder, div_by_zero, overflow}, exp);
    end
  endtask

  task automatic test_reset_mid;
    int pulses = 0, n;
    res_t exp;
    issue(8'd20, 4'd3, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero, overflow} !== '0) begin
      failures++; $display("FAIL midrst_outputs got=%b want=0", {quotient, remainder, busy, done, div_by_zero, overflow});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++; $display("FAIL midrst_no_done got=%0d want=0", pulses);
    end
    issue(8'd20, 4'd3, 1'b1);
    wait_done(n);
    exp = sb.pop_front();
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== exp || n !== 2 * W + 1) begin
      failures++; $display("FAIL midrst_recover got=%h/%0d want=%h/%0d",
                           {quotient, remainder, div_by_zero, overflow}, n, exp, 2 * W + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n;
    res_t exp;
    @(negedge clk);
    dividend = 8'd20; divisor = 4'd3; start = 1'b1;
    sb.push_back(model(8'd20, 4'd3));
    @(posedge clk); #1;
    wait_done(n);
    exp = sb.pop_front();
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== exp || n !== 2 * W + 1) begin
      failures++; $display("FAIL b2b_first got=%h/%0d want=%h/%0d",
                           {quotient, remainder, div_by_zero, overflow}, n, exp, 2 * W + 1);
    end
    dividend = 8'hEC;
    sb.push_back(model(8'hEC, 4'd3));
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL b2b_done_width got=%b want=0", done);
    end
    wait_done(n);
    start = 1'b0;
    exp = sb.pop_front();
    checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== exp || n !== 2 * W + 2) begin
      failures++; $display("FAIL b2b_second got=%h/%0d want=%h/%0d",
                           {quotient, remainder, div_by_zero, overflow}, n, exp, 2 * W + 2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [2*W-1:0] a;
    logic [W-1:0] b;
    int n;
    res_t exp;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(0, 15));
      issue(a, b, 1'b1);
      wait_done(n);
      exp = sb.pop_front();
      checks++;
      if ({quotient, remainder, div_by_zero, overflow} !== exp) begin
        failures++; $display("FAIL rand%0d a=%h b=%h got=%h want=%h", i, a, b,
                             {quotient, remainder, div_by_zero, overflow}, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_vectors();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
